pic_timer_bank: RTL and testbench
=================================

// Module: pic_timer_bank
// PURPOSE
//  Parametrised multi-channel successor to the core's TMR0 peripheral.
//  Provides NUM_CH independent WIDTH-bit up-counters for the midrange core.
//  Each channel has a TMR0-style prescaler, internal/external clock source,
//  auto-reload on overflow, a per-channel interrupt flag and an enable.
//  Sits on the core's peripheral register bus; irq feeds the core interrupt
//  logic alongside intcon_t0if.
// PARAMETERS
//  NUM_CH       4  number of timer channels (1..8)
//  WIDTH        8  counter/data width in bits (>= 8)
//  SYNC_STAGES  2  synchroniser depth on each t_ext input (>= 2)
// PORTS
//  clk        in   1                 core clock
//  rst        in   1                 synchronous, active-high reset
//  tick_en    in   1                 one-cycle instruction-cycle strobe (internal source)
//  t_ext      in   NUM_CH            external count inputs, asynchronous
//  wr_en      in   1                 register write strobe
//  wr_addr    in   $clog2(NUM_CH)+2  {channel, reg[1:0]}
//  wr_data    in   WIDTH             write data
//  rd_addr    in   $clog2(NUM_CH)+2  read address
//  rd_data    out  WIDTH             read data, combinational from rd_addr
//  gie        in   1                 global interrupt enable (from INTCON)
//  irq        out  1                 gie & |(if_vec & ie_vec)
//  if_vec     out  NUM_CH            per-channel interrupt flags
//  ovf_pulse  out  NUM_CH            1-cycle pulse on each channel overflow
// BEHAVIOUR
//  Register map per channel, reg field:
//   0 COUNT
//   1 RELOAD
//   2 CTRL
//   3 STAT: bit0 = IF, other bits read 0
//  CTRL bit fields:
//   [0] EN, [1] CS (0 = tick_en, 1 = t_ext edge), [2] SE (0 = rising, 1 = falling)
//   [3] PSA (1 = bypass prescaler), [6:4] PS (ratio 2^(PS+1)), [7] IE
//  Channel indices >= NUM_CH: reads return 0, writes are ignored.
//  Reset: COUNT = 0, RELOAD = 0, CTRL = 8'h00, IF = 0, prescalers = 0,
//   sync chains = 0, irq = 0, ovf_pulse = 0.
//  Raw event: CS=0 -> tick_en; CS=1 -> selected edge of synchronised t_ext
//   (edge detector compares the last two sync stages).
//   External latency is SYNC_STAGES+1 clk.
//  Prescaler: 8-bit counter.
//   PSA=1: count event = raw event.
//   PSA=0: prescaler increments on each raw event; a count event is issued
//    when prescaler == 2^(PS+1)-1, and the prescaler wraps to 0.
//   The prescaler is cleared on any write to COUNT or CTRL of that channel.
//  Count (EN=1 only): on a count event, COUNT <= COUNT+1.
//   If COUNT == all-ones: COUNT <= RELOAD, IF <= 1, ovf_pulse = 1 the same
//   cycle the count updates.
//   RELOAD=0 gives exact TMR0 behaviour.
//  Write inhibit: a COUNT write loads wr_data and suppresses the next 2
//   count events (2-bit inhibit counter, decremented per count event).
//   A COUNT write in the same cycle as a count event: write wins, no
//   increment, no overflow.
//  IF: a STAT write loads IF from wr_data[0].
//   Hardware set wins over a software clear in the same cycle.
//  EN=0 freezes COUNT and the prescaler; IF is still software-writable.
//  irq and if_vec are combinational from registered state, so an overflow
//   is visible on irq 1 clk after the count event.
//  rst asserted mid-operation: all state returns to reset values on the
//   next edge; any pending inhibit is dropped.
// TESTING
//  T1 ch0 CTRL=0x89 (EN, PSA, IE), gie=1, tick_en every 4th clk from
//     COUNT=0 -> COUNT=1..255, then 0; if_vec[0] and irq=1 one clk after
//     the 256th tick.
//  T2 write COUNT=0xFD, ticks continue -> COUNT stays 0xFD for 2 ticks,
//     then FE, FF, 00 with ovf_pulse[0].
//  T3 CTRL=0x81 (PSA=0, PS=0, 1:2) -> COUNT increments every 2nd tick;
//     writing PS=1 mid-count restarts the prescaler, so the next
//     increment comes after 4 ticks.
//  T4 ch1 RELOAD=0xF0, CS=1, SE=0, toggle t_ext -> overflow from FF
//     reloads F0; a falling edge with SE=0 does not count.
//  T5 STAT write IF=0 in the same cycle ch2 overflows -> IF reads 1;
//     gie=0 -> irq=0 while if_vec[2]=1.
//  T6 assert rst mid-count on all channels -> all registers 0, irq=0,
//     rd_data=0 for every address.

Source files
------------

// File: rtl/pic_timer_bank.sv
`default_nettype none
// ============================================================================
//  Module      : pic_timer_bank
//  Description : NUM_CH independent WIDTH-bit TMR0-style up-counters with
//                prescaler, internal/external clock source, auto-reload,
//                per-channel interrupt flag and a register-bus interface.
//  Revision    : 1.0  initial release
// ============================================================================
module pic_timer_bank #(
    parameter int NUM_CH      = 4,
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         tick_en,
    input  logic [NUM_CH-1:0]            t_ext,
    input  logic                         wr_en,
    input  logic [$clog2(NUM_CH)+2-1:0]  wr_addr,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic [$clog2(NUM_CH)+2-1:0]  rd_addr,
    output logic [WIDTH-1:0]             rd_data,
    input  logic                         gie,
    output logic                         irq,
    output logic [NUM_CH-1:0]            if_vec,
    output logic [NUM_CH-1:0]            ovf_pulse
);

    localparam int         c_aw       = $clog2(NUM_CH) + 2;
    localparam logic [1:0] c_reg_cnt  = 2'd0;
    localparam logic [1:0] c_reg_rld  = 2'd1;
    localparam logic [1:0] c_reg_ctrl = 2'd2;
    localparam logic [1:0] c_reg_stat = 2'd3;

    // Channel index is everything above the 2-bit register field; shifting
    // keeps this legal even when NUM_CH = 1 leaves no channel bits.
    logic [c_aw-1:0]  w_wr_ch;
    logic [c_aw-1:0]  w_rd_ch;
    logic [1:0]       w_wr_reg;
    logic [1:0]       w_rd_reg;
    logic [NUM_CH-1:0] w_ie_vec;
    logic [WIDTH-1:0] w_rd_arr [NUM_CH];

    assign w_wr_ch  = wr_addr >> 2;
    assign w_rd_ch  = rd_addr >> 2;
    assign w_wr_reg = wr_addr[1:0];
    assign w_rd_reg = rd_addr[1:0];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        // Sync stages [SYNC_STAGES-1:0] plus one extra flop holding the
        // previous synchronised value for edge detection.
        logic [SYNC_STAGES:0] r_sync_q, w_sync_d;
        logic [WIDTH-1:0]     r_cnt_q, w_cnt_d;
        logic [WIDTH-1:0]     r_rld_q, w_rld_d;
        logic [7:0]           r_ctrl_q, w_ctrl_d;
        logic [7:0]           r_ps_q, w_ps_d;
        logic [1:0]           r_inh_q, w_inh_d;
        logic                 r_if_q, w_if_d;
        logic                 r_ovf_q, w_ovf_d;

        logic       w_sel, w_wr_cnt, w_wr_rld, w_wr_ctrl, w_wr_stat;
        logic       w_rise, w_fall, w_raw, w_evt;
        logic [7:0] w_term;

        assign w_sel     = wr_en && (w_wr_ch == c_aw'(i));
        assign w_wr_cnt  = w_sel && (w_wr_reg == c_reg_cnt);
        assign w_wr_rld  = w_sel && (w_wr_reg == c_reg_rld);
        assign w_wr_ctrl = w_sel && (w_wr_reg == c_reg_ctrl);
        assign w_wr_stat = w_sel && (w_wr_reg == c_reg_stat);

        assign w_rise = r_sync_q[SYNC_STAGES-1] & ~r_sync_q[SYNC_STAGES];
        assign w_fall = ~r_sync_q[SYNC_STAGES-1] & r_sync_q[SYNC_STAGES];

        // Prescaler terminal value 2^(PS+1)-1, i.e. 1 for PS=0 up to 255 for PS=7.
        assign w_term = 8'hFF >> (3'd7 - r_ctrl_q[6:4]);

        // Raw event selection, prescaler, counter, inhibit and flag next-state.
        always_comb begin
            w_sync_d = {r_sync_q[SYNC_STAGES-1:0], t_ext[i]};
            w_rld_d  = r_rld_q;
            w_ctrl_d = r_ctrl_q;
            w_ps_d   = r_ps_q;
            w_cnt_d  = r_cnt_q;
            w_inh_d  = r_inh_q;
            w_if_d   = r_if_q;
            w_ovf_d  = 1'b0;
            w_evt    = 1'b0;

            if (!r_ctrl_q[1]) begin
                w_raw = tick_en;
            end else if (r_ctrl_q[2]) begin
                w_raw = w_fall;
            end else begin
                w_raw = w_rise;
            end

            if (w_wr_rld) begin
                w_rld_d = wr_data;
            end
            if (w_wr_ctrl) begin
                w_ctrl_d = wr_data[7:0];
            end

            // EN=0 freezes the prescaler as well as the count.
            if (r_ctrl_q[0] && w_raw) begin
                if (r_ctrl_q[3]) begin
                    w_evt = 1'b1;
                end else if (r_ps_q == w_term) begin
                    w_evt  = 1'b1;
                    w_ps_d = 8'd0;
                end else begin
                    w_ps_d = r_ps_q + 8'd1;
                end
            end
            if (w_wr_cnt || w_wr_ctrl) begin
                w_ps_d = 8'd0;
            end

            if (w_wr_stat) begin
                w_if_d = wr_data[0];
            end

            // A COUNT write beats a simultaneous count event and arms the
            // two-event inhibit; hardware flag set overrides a software clear.
            if (w_wr_cnt) begin
                w_cnt_d = wr_data;
                w_inh_d = 2'd2;
            end else if (w_evt) begin
                if (r_inh_q != 2'd0) begin
                    w_inh_d = r_inh_q - 2'd1;
                end else if (&r_cnt_q) begin
                    w_cnt_d = r_rld_q;
                    w_if_d  = 1'b1;
                    w_ovf_d = 1'b1;
                end else begin
                    w_cnt_d = r_cnt_q + WIDTH'(1);
                end
            end
        end

        // Channel state registers.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_sync_q <= '0;
                r_cnt_q  <= '0;
                r_rld_q  <= '0;
                r_ctrl_q <= 8'h00;
                r_ps_q   <= 8'd0;
                r_inh_q  <= 2'd0;
                r_if_q   <= 1'b0;
                r_ovf_q  <= 1'b0;
            end else begin
                r_sync_q <= w_sync_d;
                r_cnt_q  <= w_cnt_d;
                r_rld_q  <= w_rld_d;
                r_ctrl_q <= w_ctrl_d;
                r_ps_q   <= w_ps_d;
                r_inh_q  <= w_inh_d;
                r_if_q   <= w_if_d;
                r_ovf_q  <= w_ovf_d;
            end
        end

        assign if_vec[i]    = r_if_q;
        assign ovf_pulse[i] = r_ovf_q;
        assign w_ie_vec[i]  = r_ctrl_q[7];

        assign w_rd_arr[i] = (w_rd_reg == c_reg_cnt)  ? r_cnt_q :
                             (w_rd_reg == c_reg_rld)  ? r_rld_q :
                             (w_rd_reg == c_reg_ctrl) ? WIDTH'(r_ctrl_q) :
                                                        WIDTH'(r_if_q);
    end

    // Read mux; unpopulated channel indices read as zero.
    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (w_rd_ch == c_aw'(k)) begin
                rd_data = w_rd_arr[k];
            end
        end
    end

    assign irq = gie & |(if_vec & w_ie_vec);

endmodule
`default_nettype wire

// File: tb/tb_pic_timer_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pic_timer_bank
//  Description : Self-checking bench for pic_timer_bank: directed scenarios
//                followed by random traffic against a behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pic_timer_bank;

    localparam int NUM_CH      = 4;
    localparam int WIDTH       = 8;
    localparam int SYNC_STAGES = 2;
    localparam int AW          = $clog2(NUM_CH) + 2;
    localparam int MAXV        = (1 << WIDTH) - 1;

    logic              clk = 1'b0;
    logic              rst, tick_en, wr_en, gie, irq;
    logic [NUM_CH-1:0] t_ext, if_vec, ovf_pulse;
    logic [AW-1:0]     wr_addr, rd_addr;
    logic [WIDTH-1:0]  wr_data, rd_data;

    int total = 0;
    int bad   = 0;

    // Behavioural model state, one entry per channel.
    int m_cnt [NUM_CH];
    int m_rld [NUM_CH];
    int m_ctrl[NUM_CH];
    int m_if  [NUM_CH];
    int m_ps  [NUM_CH];
    int m_inh [NUM_CH];
    int m_ovf [NUM_CH];
    int m_h   [NUM_CH][SYNC_STAGES+1];  // t_ext samples, [0] most recent

    pic_timer_bank #(
        .NUM_CH      (NUM_CH),
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tick_en   (tick_en),
        .t_ext     (t_ext),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .gie       (gie),
        .irq       (irq),
        .if_vec    (if_vec),
        .ovf_pulse (ovf_pulse)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "bench timeout");
    end

    function automatic int m_read(input int a);
        int ch;
        int r;
        ch = a >> 2;
        r  = a & 3;
        if (ch >= NUM_CH) return 0;
        case (r)
            0:       return m_cnt[ch];
            1:       return m_rld[ch];
            2:       return m_ctrl[ch];
            default: return m_if[ch];
        endcase
    endfunction

    function automatic int m_ifvec();
        int v = 0;
        for (int c = 0; c < NUM_CH; c++) v |= (m_if[c] & 1) << c;
        return v;
    endfunction

    function automatic int m_ovfvec();
        int v = 0;
        for (int c = 0; c < NUM_CH; c++) v |= (m_ovf[c] & 1) << c;
        return v;
    endfunction

    function automatic int m_irq();
        int v = 0;
        for (int c = 0; c < NUM_CH; c++)
            if (m_if[c] == 1 && ((m_ctrl[c] >> 7) & 1) == 1) v = 1;
        return gie ? v : 0;
    endfunction

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        int  a, r, ch, d, ctl, ratio, nps, ncnt, ninh, nif, novf;
        bit  wsel, rise, fall, raw, evt;
        a  = int'(wr_addr);
        ch = a >> 2;
        r  = a & 3;
        d  = int'(wr_data);
        for (int c = 0; c < NUM_CH; c++) begin
            if (rst) begin
                m_cnt[c] = 0; m_rld[c] = 0; m_ctrl[c] = 0; m_if[c] = 0;
                m_ps[c]  = 0; m_inh[c] = 0; m_ovf[c]  = 0;
                for (int j = 0; j <= SYNC_STAGES; j++) m_h[c][j] = 0;
            end else begin
                wsel = wr_en && (ch == c);
                ctl  = m_ctrl[c];
                rise = (m_h[c][SYNC_STAGES-1] == 1) && (m_h[c][SYNC_STAGES] == 0);
                fall = (m_h[c][SYNC_STAGES-1] == 0) && (m_h[c][SYNC_STAGES] == 1);
                if (((ctl >> 1) & 1) == 0)      raw = tick_en;
                else if (((ctl >> 2) & 1) == 1) raw = fall;
                else                            raw = rise;
                evt = 0;
                nps = m_ps[c];
                if ((ctl & 1) == 1 && raw) begin
                    if (((ctl >> 3) & 1) == 1) begin
                        evt = 1;
                    end else begin
                        ratio = 1 << (((ctl >> 4) & 7) + 1);
                        nps   = (m_ps[c] + 1) % ratio;
                        evt   = (nps == 0);
                    end
                end
                if (wsel && (r == 0 || r == 2)) nps = 0;
                nif  = m_if[c];
                ncnt = m_cnt[c];
                ninh = m_inh[c];
                novf = 0;
                if (wsel && r == 3) nif = d & 1;
                if (wsel && r == 0) begin
                    ncnt = d;
                    ninh = 2;
                end else if (evt) begin
                    if (m_inh[c] > 0) ninh = m_inh[c] - 1;
                    else if (m_cnt[c] == MAXV) begin
                        ncnt = m_rld[c]; nif = 1; novf = 1;
                    end else ncnt = m_cnt[c] + 1;
                end
                if (wsel && r == 1) m_rld[c]  = d;
                if (wsel && r == 2) m_ctrl[c] = d & 8'hFF;
                m_cnt[c] = ncnt;
                m_inh[c] = ninh;
                m_if[c]  = nif;
                m_ovf[c] = novf;
                m_ps[c]  = nps;
                for (int j = SYNC_STAGES; j > 0; j--) m_h[c][j] = m_h[c][j-1];
                m_h[c][0] = int'(t_ext[c]);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_rd"},  32'(rd_data),   m_read(int'(rd_addr)));
        chk({tag, "_irq"}, 32'(irq),       m_irq());
        chk({tag, "_if"},  32'(if_vec),    m_ifvec());
        chk({tag, "_ovf"}, 32'(ovf_pulse), m_ovfvec());
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_all("model");
    endtask

    task automatic wr(input int a, input int d);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = WIDTH'(d);
        cycle();
        wr_en   = 1'b0;
    endtask

    int t2_exp[5] = '{8'hFD, 8'hFD, 8'hFE, 8'hFF, 8'h00};
    int t3_exp[9] = '{0, 1, 1, 2, 2, 2, 2, 2, 3};
    int t4_exp[4] = '{8'hFE, 8'hFE, 8'hFF, 8'hF0};

    initial begin
        rst = 1'b1; tick_en = 1'b0; t_ext = '0; wr_en = 1'b0;
        wr_addr = '0; wr_data = '0; rd_addr = '0; gie = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;

        // Reset state across every address
        for (int a = 0; a < (NUM_CH * 4); a++) begin
            rd_addr = AW'(a);
            cycle();
            chk("reset_rd", 32'(rd_data), 0);
        end
        chk("reset_irq", 32'(irq), 0);
        chk("reset_if",  32'(if_vec), 0);
        chk("reset_ovf", 32'(ovf_pulse), 0);

        // T1: ch0 internal ticks, no prescaler, full wrap
        gie = 1'b1;
        wr(2, 8'h89);
        rd_addr = AW'(0);
        for (int t = 0; t < 256; t++) begin
            tick_en = 1'b1;
            cycle();
            tick_en = 1'b0;
            if (t == 255) begin
                chk("t1_wrap_cnt", 32'(rd_data), 0);
                chk("t1_if0",      32'(if_vec[0]), 1);
                chk("t1_irq",      32'(irq), 1);
                chk("t1_ovf0",     32'(ovf_pulse[0]), 1);
            end else begin
                chk("t1_cnt", 32'(rd_data), t + 1);
                if (t == 254) chk("t1_irq_pre", 32'(irq), 0);
            end
            cycle();
            if (t == 255) chk("t1_ovf_clr", 32'(ovf_pulse[0]), 0);
            cycle();
            cycle();
        end

        // T2: COUNT write inhibits the next two count events
        wr(3, 0);
        chk("t2_if_clr", 32'(if_vec[0]), 0);
        wr(0, 8'hFD);
        for (int i = 0; i < 5; i++) begin
            tick_en = 1'b1;
            cycle();
            tick_en = 1'b0;
            chk("t2_cnt", 32'(rd_data), t2_exp[i]);
            chk("t2_ovf", 32'(ovf_pulse[0]), 32'(i == 4));
            cycle(); cycle(); cycle();
        end
        chk("t2_if_set", 32'(if_vec[0]), 1);

        // T3: prescaler 1:2, then PS=1 written mid-count restarts it at 1:4
        wr(2, 8'h81);
        for (int i = 0; i < 9; i++) begin
            if (i == 5) wr(2, 8'h91);
            tick_en = 1'b1;
            cycle();
            tick_en = 1'b0;
            chk("t3_cnt", 32'(rd_data), t3_exp[i]);
            cycle(); cycle(); cycle();
        end

        // T4: ch1 external rising edges with reload
        wr(6, 8'h8B);
        wr(5, 8'hF0);
        wr(4, 8'hFE);
        rd_addr = AW'(4);
        for (int i = 0; i < 4; i++) begin
            t_ext[1] = 1'b1;
            cycle(); cycle(); cycle(); cycle();
            chk("t4_cnt_rise", 32'(rd_data), t4_exp[i]);
            t_ext[1] = 1'b0;
            cycle(); cycle(); cycle(); cycle();
            chk("t4_cnt_fall", 32'(rd_data), t4_exp[i]);
        end
        chk("t4_if1", 32'(if_vec[1]), 1);

        // T5: STAT clear collides with overflow; gie gating
        wr(10, 8'h89);
        wr(8, 8'hFF);
        rd_addr = AW'(11);
        for (int i = 0; i < 2; i++) begin
            tick_en = 1'b1;
            cycle();
            tick_en = 1'b0;
            cycle(); cycle(); cycle();
        end
        chk("t5_if_pre", 32'(rd_data), 0);
        tick_en = 1'b1;
        wr(11, 0);
        tick_en = 1'b0;
        chk("t5_if_rd", 32'(rd_data), 1);
        chk("t5_ifvec", 32'(if_vec[2]), 1);
        chk("t5_irq_on", 32'(irq), 1);
        gie = 1'b0;
        cycle();
        chk("t5_irq_gated", 32'(irq), 0);
        chk("t5_ifvec_held", 32'(if_vec[2]), 1);

        // Random traffic against the model
        for (int n = 0; n < 800; n++) begin
            tick_en = 1'($urandom);
            t_ext   = NUM_CH'($urandom);
            gie     = 1'($urandom);
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_addr = AW'($urandom);
            wr_data = WIDTH'($urandom);
            rd_addr = AW'($urandom);
            cycle();
        end
        wr_en = 1'b0;

        // T6: reset mid-count drops everything including a pending inhibit
        wr(0, 8'h10);
        rst     = 1'b1;
        tick_en = 1'b1;
        t_ext   = NUM_CH'($urandom);
        cycle();
        tick_en = 1'b0;
        for (int a = 0; a < (NUM_CH * 4); a++) begin
            rd_addr = AW'(a);
            cycle();
            chk("t6_rd", 32'(rd_data), 0);
        end
        chk("t6_irq", 32'(irq), 0);
        chk("t6_if",  32'(if_vec), 0);
        chk("t6_ovf", 32'(ovf_pulse), 0);
        rst   = 1'b0;
        t_ext = '0;
        gie   = 1'b1;
        wr(2, 8'h89);
        rd_addr = AW'(0);
        tick_en = 1'b1;
        cycle();
        tick_en = 1'b0;
        chk("t6_inh_drop", 32'(rd_data), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
